seq_11011_framer_tx: RTL and testbench
======================================

SEQ_11011_FRAMER_TX -- requirements
Module: seq_11011_framer_tx

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 8: payload width in bits, legal range 1..16.
REQ-002 The block SHALL have parameter PAR_ODD, default 0: 0 selects even parity, 1 selects odd parity.

Ports:
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data  input  DATA_W  payload word, sampled on accept.
REQ-006 load  input  1  request to send one frame carrying data.
REQ-007 ready  output  1  block can accept load this cycle.
REQ-008 x  output  1  serial frame bit stream, registered.
REQ-009 busy  output  1  a frame is in flight (SYNC, DATA or PAR state).
REQ-010 done  output  1  one-cycle pulse during the parity bit.
REQ-011 frames_sent  output  8  count of completed frames.

Function
REQ-012 The block SHALL implement a four-state FSM: IDLE, SYNC, DATA, PAR.
REQ-013 The block SHALL emit frames of 5+DATA_W+1 bits in this order: sync marker 1,1,0,1,1; payload MSB first; one parity bit.
REQ-014 Parity SHALL be computed over the payload only: XOR of data bits, inverted when PAR_ODD=1.
REQ-015 ready SHALL equal (state==IDLE or state==PAR) and not rst, as a combinational function of state.
REQ-016 Accept SHALL occur on a rising edge where load and ready are both 1; data is latched into a shift register at that edge.
REQ-017 load while ready=0 SHALL be ignored: no queuing, and the frame in flight is unaffected.
REQ-018 Latency: on accept at edge k, x SHALL carry sync bit 0 during the cycle after k; a full frame occupies cycles k+1 .. k+6+DATA_W.
REQ-019 SYNC SHALL last exactly 5 cycles, counted by a 3-bit index; DATA SHALL last exactly DATA_W cycles, counted by a bit counter; PAR SHALL last 1 cycle.
REQ-020 Transitions:
- IDLE->SYNC on accept.
- SYNC->DATA after the 5th sync bit.
- DATA->PAR after the last payload bit.
- PAR->SYNC on accept in PAR; otherwise PAR->IDLE.
REQ-021 In IDLE, x SHALL be 0 and busy SHALL be 0.
REQ-022 done SHALL be 1 exactly in the PAR cycle and 0 otherwise.
REQ-023 frames_sent SHALL increment by 1 at the edge ending each PAR cycle and SHALL wrap 255->0.
REQ-024 Back-to-back: an accept in PAR SHALL make the next frame's first sync bit immediately follow the parity bit, with no idle gap.
REQ-025 data changing after accept SHALL NOT alter the frame in flight.

Reset
REQ-026 With rst=1 at an edge, the block SHALL set state=IDLE, x=0, done=0, busy=0, frames_sent=0, and clear the counters and shift register, regardless of load.
REQ-027 Reset mid-frame SHALL abort the frame: no done pulse, no counter increment, and the frame is not resumed.
REQ-028 ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-029 Even-parity frame: DATA_W=8, PAR_ODD=0, accept data=8'hA5 -> x = 11011 10100101 0 over 14 cycles; done high in cycle 14 only; frames_sent=1.
REQ-030 Parity set: accept data=8'h07 (PAR_ODD=0) -> parity bit 1; with PAR_ODD=1 -> parity bit 0.
REQ-031 Back-to-back: accept 8'hFF, hold load=1 with data=8'h00 through the PAR cycle -> 28 contiguous bits 11011 11111111 0 11011 00000000 0; busy never drops; frames_sent=2.
REQ-032 Ignored load: pulse load with 8'h3C during DATA of an 8'hA5 frame -> the A5 frame is unchanged and no second frame is sent.
REQ-033 Reset mid-frame: assert rst in the 3rd payload cycle -> x=0 and busy=0 next cycle, no done pulse, frames_sent=0; a new accept then sends a complete frame.
REQ-034 Wrap: send 256 frames -> frames_sent reads 0, with done pulsing 256 times.

Source files
------------

// File: rtl/seq_11011_framer_tx.sv
// seq_11011_framer_tx: serial framer sending sync 11011, MSB-first payload and a parity bit
module seq_11011_framer_tx #(
    parameter int DATA_W  = 8,
    parameter int PAR_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              load,
    output logic              ready,
    output logic              x,
    output logic              busy,
    output logic              done,
    output logic [7:0]        frames_sent
);
    typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;
    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              par_q, par_d;
    logic              x_q, x_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        frames_q, frames_d;
    logic              accept;

    assign ready       = (state_q == IDLE || state_q == PAR) && !rst;
    assign accept      = load && ready;
    assign x           = x_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frames_sent = frames_q;

    // Next state; outputs are derived from the next state so they stay aligned with it once registered
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        par_d    = par_q;
        frames_d = (state_q == PAR) ? frames_q + 8'd1 : frames_q;
        case (state_q)
            IDLE, PAR: begin
                if (accept) begin
                    state_d = SYNC;
                    idx_d   = 3'd0;
                    cnt_d   = 5'd0;
                    sh_d    = data;
                    par_d   = (^data) ^ (PAR_ODD != 0);
                end else begin
                    state_d = IDLE;
                end
            end
            SYNC: begin
                if (idx_q == 3'd4) begin
                    state_d = DATA;
                    cnt_d   = 5'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            DATA: begin
                if (cnt_q == 5'(DATA_W - 1)) begin
                    state_d = PAR;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                    sh_d  = sh_q << 1;
                end
            end
            default: state_d = IDLE;
        endcase
        x_d    = state_d == SYNC ? idx_d != 3'd2 :
                 state_d == DATA ? sh_d[DATA_W-1] :
                 state_d == PAR  ? par_d : 1'b0;
        busy_d = state_d != IDLE;
        done_d = state_d == PAR;
    end

    // State and registered outputs, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            sh_q     <= '0;
            par_q    <= 1'b0;
            x_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            par_q    <= par_d;
            x_q      <= x_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            frames_q <= frames_d;
        end
    end
endmodule

// File: tb/tb_seq_11011_framer_tx.sv
// tb_seq_11011_framer_tx: scoreboard bench driving an even- and an odd-parity framer in lockstep
module tb_seq_11011_framer_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready0, x0, busy0, done0, ready1, x1, busy1, done1;
    logic [7:0] frames0, frames1;

    int n_chk = 0;
    int n_fail = 0;
    int dut_dones = 0;
    int pushes = 0;
    logic [7:0] cnt_m = 8'd0;
    // entry: {last bit of frame, odd-parity DUT bit, even-parity DUT bit}
    logic [2:0] q[$];

    seq_11011_framer_tx #(.DATA_W(8), .PAR_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .data(data), .load(load), .ready(ready0),
        .x(x0), .busy(busy0), .done(done0), .frames_sent(frames0));
    seq_11011_framer_tx #(.DATA_W(8), .PAR_ODD(1)) dut1 (
        .clk(clk), .rst(rst), .data(data), .load(load), .ready(ready1),
        .x(x1), .busy(busy1), .done(done1), .frames_sent(frames1));

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] d);
        logic [12:0] f;
        logic        pe;
        f  = {5'b11011, d};
        pe = ($countones(d) % 2) == 1;
        for (int i = 0; i < 13; i++) q.push_back({1'b0, f[12-i], f[12-i]});
        q.push_back({1'b1, ~pe, pe});
        pushes++;
    endtask

    task automatic step(input logic r, input logic l, input logic [7:0] d);
        @(negedge clk);
        #1;
        rst  = r;
        load = l;
        data = d;
        if (r) begin
            q.delete();
            cnt_m = 8'd0;
        end else if (l && q.size() == 0) begin
            push_frame(d);
        end
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() > 0 && g < 100) begin
            step(1'b0, 1'b0, 8'h00);
            g++;
        end
        step(1'b0, 1'b0, 8'h00);
        chk("drain_timeout", q.size(), 0);
    endtask

    always @(negedge clk) begin
        logic [2:0] e;
        logic       have, exp_rdy;
        have    = q.size() > 0;
        exp_rdy = !rst && q.size() <= 1;
        e       = have ? q.pop_front() : 3'b000;
        chk("ready0", ready0, exp_rdy);
        chk("ready1", ready1, exp_rdy);
        chk("x_even", x0, e[0]);
        chk("x_odd", x1, e[1]);
        chk("busy0", busy0, have);
        chk("busy1", busy1, have);
        chk("done0", done0, have && e[2]);
        chk("done1", done1, have && e[2]);
        chk("frames0", frames0, cnt_m);
        chk("frames1", frames1, cnt_m);
        if (done0) dut_dones++;
        if (have && e[2]) cnt_m++;
    end

    initial begin
        int base;
        int g;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        base = dut_dones;
        step(1'b0, 1'b1, 8'hA5);
        repeat (16) step(1'b0, 1'b0, 8'h00);
        chk("a5_frames", frames0, 1);
        chk("a5_dones", dut_dones - base, 1);
        step(1'b0, 1'b1, 8'h07);
        drain();
        chk("p07_frames", frames1, 2);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        repeat (14) step(1'b0, 1'b1, 8'h00);
        drain();
        chk("b2b_frames", frames0, 2);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hA5);
        repeat (8) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h3C);
        drain();
        chk("ignored_frames", frames0, 1);
        step(1'b1, 1'b0, 8'h00);
        base = dut_dones;
        step(1'b0, 1'b1, 8'hA5);
        repeat (7) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        repeat (20) step(1'b0, 1'b0, 8'h00);
        chk("abort_dones", dut_dones - base, 0);
        chk("abort_frames", frames0, 0);
        step(1'b0, 1'b1, 8'h5A);
        drain();
        chk("after_abort_frames", frames0, 1);
        step(1'b1, 1'b0, 8'h00);
        repeat (800) step($urandom_range(59) == 0, $urandom_range(2) == 0, 8'($urandom));
        drain();
        step(1'b1, 1'b0, 8'h00);
        base   = dut_dones;
        pushes = 0;
        g      = 0;
        while (pushes < 256 && g < 5000) begin
            step(1'b0, 1'b1, 8'($urandom));
            g++;
        end
        drain();
        chk("wrap_pushes", pushes, 256);
        chk("wrap_frames0", frames0, 0);
        chk("wrap_frames1", frames1, 0);
        chk("wrap_dones", dut_dones - base, 256);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
